// File: rtl/zuc_eia3_mac_if.sv
// Handshake and result bundle between the EIA3 MAC and its keystream/message sources.
interface zuc_eia3_mac_if;
  logic        start;
  logic [31:0] length;
  logic [31:0] ks_word;
  logic        ks_valid;
  logic        ks_ready;
  logic [31:0] msg_word;
  logic        msg_valid;
  logic        msg_ready;
  logic [31:0] mac;
  logic        mac_valid;
  logic        busy;

  modport master (
    output start, length, ks_word, ks_valid, msg_word, msg_valid,
    input  ks_ready, msg_ready, mac, mac_valid, busy
  );

  modport slave (
    input  start, length, ks_word, ks_valid, msg_word, msg_valid,
    output ks_ready, msg_ready, mac, mac_valid, busy
  );
endinterface

// File: rtl/zuc_eia3_mac.sv
// 128-EIA3 integrity MAC, one message bit per clock over a 64-bit keystream window.
// Build macro EIA3_ZERO_SKIP_EN: jump over all-zero tails of a message word in one cycle.
module zuc_eia3_mac (
  input  logic          clk,
  input  logic          rstn,
  zuc_eia3_mac_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME0, S_PRIME1, S_RUN, S_FINAL} state_t;

  // 32 keystream bits starting 'off' bits into the window
  function automatic logic [31:0] win32(input logic [63:0] w, input logic [4:0] off);
    logic [63:0] s;
    s = w << off;
    return s[63:32];
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_len, w_len_nxt;
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [4:0]  r_b, w_b_nxt;
  logic [31:0] r_mac, w_mac_nxt;
  logic        r_mac_valid, w_mac_valid_nxt;
  logic [63:0] r_w, w_w_nxt;
  logic [31:0] r_t, w_t_nxt;
  logic [31:0] r_word, w_word_nxt;

  logic [4:0]  w_p;
  logic [31:0] w_cur_word;
  logic [31:0] w_hi;
  logic        w_last;
  logic        w_run_go;
  logic        w_ks_ready;
  logic        w_msg_ready;

  assign w_p        = r_len[4:0];
  assign w_cur_word = (r_b == 5'd0) ? bus.msg_word : r_word;
  assign w_hi       = w_cur_word << r_b;
  assign w_last     = (r_cnt + 32'd1) == r_len;
  assign w_run_go   = (r_b == 5'd0)  ? bus.msg_valid :
                      (r_b == 5'd31) ? bus.ks_valid  : 1'b1;

  assign w_ks_ready  = (r_state == S_PRIME0) || (r_state == S_PRIME1) ||
                       ((r_state == S_RUN) && (r_b == 5'd31)) ||
                       ((r_state == S_FINAL) && (w_p != 5'd0));
  assign w_msg_ready = (r_state == S_RUN) && (r_b == 5'd0);

`ifdef EIA3_ZERO_SKIP_EN
  logic [31:0] w_rem;
  logic [31:0] w_span;
  logic        w_skip_full;
  logic        w_skip_tail;

  // w_span: bits left in this word; w_rem: bits left in the message
  assign w_rem       = r_len - r_cnt;
  assign w_span      = 32'd32 - {27'd0, r_b};
  assign w_skip_full = (w_hi == 32'd0) && (r_b != 5'd31) && (w_rem >= w_span);
  assign w_skip_tail = (w_rem < w_span) && ((w_hi >> (32'd32 - w_rem)) == 32'd0);
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_cnt_nxt       = r_cnt;
    w_b_nxt         = r_b;
    w_mac_nxt       = r_mac;
    w_mac_valid_nxt = 1'b0;
    w_w_nxt         = r_w;
    w_t_nxt         = r_t;
    w_word_nxt      = r_word;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_len_nxt   = bus.length;
          w_t_nxt     = 32'd0;
          w_cnt_nxt   = 32'd0;
          w_b_nxt     = 5'd0;
          w_state_nxt = S_PRIME0;
        end
      end
      S_PRIME0: begin
        if (bus.ks_valid) begin
          w_w_nxt[63:32] = bus.ks_word;
          w_state_nxt    = S_PRIME1;
        end
      end
      S_PRIME1: begin
        if (bus.ks_valid) begin
          w_w_nxt[31:0] = bus.ks_word;
          w_state_nxt   = (r_len == 32'd0) ? S_FINAL : S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_go) begin
          if (r_b == 5'd0) w_word_nxt = bus.msg_word;
          if (w_hi[31]) w_t_nxt = r_t ^ win32(r_w, r_b);
          if (r_b == 5'd31) w_w_nxt = {r_w[31:0], bus.ks_word};
          w_cnt_nxt = r_cnt + 32'd1;
          w_b_nxt   = r_b + 5'd1;
          if (w_last) w_state_nxt = S_FINAL;
`ifdef EIA3_ZERO_SKIP_EN
          // Remaining bits are zero: stop one short of the word end so the
          // keystream shift still happens on the b==31 cycle.
          if (w_skip_full) begin
            w_cnt_nxt = r_cnt + {27'd0, 5'd31 - r_b};
            w_b_nxt   = 5'd31;
          end else if (w_skip_tail) begin
            w_state_nxt = S_FINAL;
          end
`endif
        end
      end
      S_FINAL: begin
        if ((w_p == 5'd0) || bus.ks_valid) begin
          w_mac_nxt       = r_t ^ win32(r_w, w_p) ^
                            ((w_p == 5'd0) ? r_w[31:0] : bus.ks_word);
          w_mac_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_len       <= 32'd0;
      r_cnt       <= 32'd0;
      r_b         <= 5'd0;
      r_mac       <= 32'd0;
      r_mac_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_b         <= w_b_nxt;
      r_mac       <= w_mac_nxt;
      r_mac_valid <= w_mac_valid_nxt;
    end
  end

  // Datapath registers are always (re)loaded before use, so they carry no reset
  always_ff @(posedge clk) begin
    r_w    <= w_w_nxt;
    r_t    <= w_t_nxt;
    r_word <= w_word_nxt;
  end

  assign bus.ks_ready  = w_ks_ready;
  assign bus.msg_ready = w_msg_ready;
  assign bus.mac       = r_mac;
  assign bus.mac_valid = r_mac_valid;
  assign bus.busy      = (r_state != S_IDLE);

endmodule
